// File: rtl/conv_lane_collector.sv
// Collects results from P convolution lanes into per-lane FIFOs and replays them
// as one in-order y[0..L-1] stream per frame on a single valid/ready port.
module conv_lane_collector #(
  parameter int P     = 4,
  parameter int T     = 16,
  parameter int L     = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P*T-1:0]        lane_data,
  input  logic [P-1:0]          lane_valid,
  output logic [P-1:0]          lane_ready,
  output logic [T-1:0]          y_data,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [$clog2(L)-1:0]  out_idx,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int IW   = $clog2(L);
  localparam int PTRW = $clog2(P);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;

  logic [P-1:0]    lane_nempty;
  logic [P-1:0]    pop_lane;
  logic [T-1:0]    head_data [P];
  logic            y_valid_raw;
  logic            pop;

  // One circular FIFO per lane; ready depends on stored occupancy only.
  for (genvar gi = 0; gi < P; gi++) begin : lane_g
    logic [T-1:0]  mem_q [DEPTH];
    logic [T-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;

    assign lane_ready[gi]  = !reset && (cnt_q < CW'(DEPTH));
    assign push            = lane_valid[gi] && lane_ready[gi];
    assign lane_nempty[gi] = (cnt_q != '0);
    assign head_data[gi]   = mem_q[rd_q];
    assign pop_lane[gi]    = pop && (ptr_q == PTRW'(gi));

    always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
        mem_d[wr_q] = lane_data[gi*T +: T];
        wr_d        = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop_lane[gi]) begin
        rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      if (push && !pop_lane[gi]) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!push && pop_lane[gi]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign y_valid_raw = lane_nempty[ptr_q];
  assign pop         = !reset && y_valid_raw && y_ready;

  // Frame end always returns to lane 0, even when L is not a multiple of P.
  always_comb begin
    ptr_d  = ptr_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (pop) begin
      if (idx_q == IW'(L - 1)) begin
        idx_d  = '0;
        ptr_d  = '0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
        ptr_d = (ptr_q == PTRW'(P - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  assign y_valid    = !reset && y_valid_raw;
  assign y_data     = reset ? '0 : head_data[ptr_q];
  assign out_idx    = reset ? '0 : idx_q;
  assign frame_done = !reset && done_q;
  assign busy       = !reset && ((|lane_nempty) || (idx_q != '0));

endmodule

// File: tb/tb_conv_lane_collector.sv
// Randomised bench: frames are generated as whole y[] sequences, split across
// lanes, and the output stream is scoreboarded against that sequence.
module tb_conv_lane_collector;

  localparam int P     = 4;
  localparam int T     = 16;
  localparam int L     = 30;
  localparam int DEPTH = 2;
  localparam int IW    = $clog2(L);

  logic              clk = 1'b0;
  logic              reset;
  logic [P*T-1:0]    lane_data;
  logic [P-1:0]      lane_valid;
  logic [P-1:0]      lane_ready;
  logic [T-1:0]      y_data;
  logic              y_valid;
  logic              y_ready;
  logic [IW-1:0]     out_idx;
  logic              frame_done;
  logic              busy;

  conv_lane_collector #(.P(P), .T(T), .L(L), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .y_data     (y_data),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .out_idx    (out_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [T-1:0] exp_q [$];
  logic [T-1:0] src [P][$];
  int           occ [P];
  int           exp_idx   = 0;
  int           pop_count = 0;
  bit           done_exp  = 1'b0;
  logic [P-1:0] accepted  = '0;

  int vprob, rprob, ready_hold;
  int hold [P];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: y[n] belongs to lane n%P; occupancy is pushes minus pops per lane.
  always @(negedge clk) begin
    logic [P-1:0] exp_ready;
    int           lane;
    if (reset) begin
      chk("rst_y_valid", 32'(y_valid), 32'd0);
      chk("rst_lane_ready", 32'(lane_ready), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_y_data", 32'(y_data), 32'd0);
      for (int i = 0; i < P; i++) occ[i] = 0;
      exp_idx  = 0;
      done_exp = 1'b0;
      exp_q.delete();
      accepted = '0;
    end else begin
      lane = exp_idx % P;
      for (int i = 0; i < P; i++) exp_ready[i] = (occ[i] < DEPTH);
      chk("lane_ready", 32'(lane_ready), 32'(exp_ready));
      chk("y_valid", 32'(y_valid), 32'(occ[lane] > 0));
      chk("out_idx", 32'(out_idx), 32'(exp_idx));
      chk("busy", 32'(busy), 32'(((occ[0] + occ[1] + occ[2] + occ[3]) > 0) || (exp_idx != 0)));
      chk("frame_done", 32'(frame_done), 32'(done_exp));
      if (y_valid) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'(y_valid), 32'd0);
        else                   chk("y_data", 32'(y_data), 32'(exp_q[0]));
      end
      accepted = lane_valid & lane_ready;
      done_exp = 1'b0;
      if (y_valid && y_ready && exp_q.size() > 0) begin
        $display("y[%0d] = %0h from lane %0d", exp_idx, exp_q[0], lane);
        void'(exp_q.pop_front());
        occ[lane]--;
        pop_count++;
        if (exp_idx == L - 1) begin
          exp_idx  = 0;
          done_exp = 1'b1;
        end else begin
          exp_idx++;
        end
      end
      for (int i = 0; i < P; i++) if (accepted[i]) occ[i]++;
    end
  end

  task automatic gen_frame(input bit ramp);
    logic [T-1:0] v;
    for (int n = 0; n < L; n++) begin
      v = ramp ? T'(10 * (n + 1)) : T'($urandom_range(0, 65535));
      exp_q.push_back(v);
      src[n % P].push_back(v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < P; i++)
      if (accepted[i] && src[i].size() > 0) void'(src[i].pop_front());
    for (int i = 0; i < P; i++) begin
      lane_valid[i] = (src[i].size() > 0) && (hold[i] == 0) && ($urandom_range(0, 99) < vprob);
      lane_data[i*T +: T] = (src[i].size() > 0) ? src[i][0] : '0;
      if (hold[i] > 0) hold[i]--;
    end
    if (ready_hold > 0) begin
      y_ready = 1'b0;
      ready_hold--;
    end else begin
      y_ready = ($urandom_range(0, 99) < rprob);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d samples left, expected 0", exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    lane_valid = '0;
    y_ready    = 1'b0;
    for (int i = 0; i < P; i++) src[i].delete();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    reset      = 1'b1;
    lane_valid = '0;
    lane_data  = '0;
    y_ready    = 1'b0;
    vprob      = 100;
    rprob      = 100;
    ready_hold = 0;
    for (int i = 0; i < P; i++) begin
      hold[i] = 0;
      occ[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Ramp data, free-flowing: two back-to-back frames with L not a multiple of P.
    gen_frame(1'b1);
    gen_frame(1'b1);
    drain(400);

    // Lane 0 starts late while the other lanes fill up.
    hold = '{5, 0, 0, 0};
    gen_frame(1'b0);
    drain(400);

    // Output stalled for 10 cycles with all lanes pushing.
    ready_hold = 10;
    gen_frame(1'b0);
    drain(400);

    // Reset after 13 pops with FIFOs partly full, then a fresh frame.
    gen_frame(1'b0);
    base = pop_count;
    n    = 0;
    while (pop_count < base + 13 && n < 200) begin
      step();
      n++;
    end
    chk("pops_before_reset", 32'(pop_count - base >= 13), 32'd1);
    do_reset(1);
    gen_frame(1'b1);
    drain(400);

    // Random lane stalls and output backpressure over three frames.
    vprob = 60;
    rprob = 50;
    repeat (3) gen_frame(1'b0);
    drain(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
